// File: rtl/object_bbox_tracker.sv
// Object bounding-box / centroid tracker.
// Accumulates per-frame object statistics from the thresholded pixel stream.
// At frame end it snapshots them and runs two restoring dividers (sum/count)
// to produce the centroid. One registered result is presented per frame.
module object_bbox_tracker #(
    parameter int MIN_PIXELS = 64,
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int CNT_W      = 19,
    parameter int SUM_W      = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             object_pixel,
    input  logic [X_W-1:0]   x,
    input  logic [Y_W-1:0]   y,
    input  logic             pixel_valid,
    input  logic             frame_valid,
    output logic [X_W-1:0]   bbox_x_min,
    output logic [X_W-1:0]   bbox_x_max,
    output logic [Y_W-1:0]   bbox_y_min,
    output logic [Y_W-1:0]   bbox_y_max,
    output logic [X_W-1:0]   centroid_x,
    output logic [Y_W-1:0]   centroid_y,
    output logic [CNT_W-1:0] pixel_count,
    output logic             object_found,
    output logic             result_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int                STEP_W    = $clog2(SUM_W + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SUM_W);
    localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_PIXELS);

    typedef enum logic [1:0] {A_SYNC, A_WAIT, A_ACCUM} acc_state_t;
    typedef enum logic [1:0] {D_IDLE, D_DIV, D_SHORT} div_state_t;

    acc_state_t       acc_q;
    div_state_t       div_q;
    logic             fv_q;

    // Live per-frame accumulators
    logic [X_W-1:0]   min_x_q, max_x_q;
    logic [Y_W-1:0]   min_y_q, max_y_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SUM_W-1:0] sum_x_q, sum_y_q;

    // Snapshot / divider state
    logic [CNT_W-1:0]  hold_cnt_q;
    logic [X_W-1:0]    hold_x_min_q, hold_x_max_q;
    logic [Y_W-1:0]    hold_y_min_q, hold_y_max_q;
    logic [SUM_W-1:0]  quo_x_q, quo_y_q, quo_x_d, quo_y_d;
    logic [CNT_W-1:0]  rem_x_q, rem_y_q, rem_x_d, rem_y_d;
    logic [STEP_W-1:0] step_q;

    // Registered outputs
    logic [X_W-1:0]   bbox_x_min_q, bbox_x_max_q, centroid_x_q;
    logic [Y_W-1:0]   bbox_y_min_q, bbox_y_max_q, centroid_y_q;
    logic [CNT_W-1:0] pixel_count_q;
    logic             object_found_q, result_valid_q, busy_q, overrun_q;

    logic rise, fall, hit, snap;

    assign rise = frame_valid & ~fv_q;
    assign fall = ~frame_valid & fv_q;
    assign hit  = frame_valid & pixel_valid & object_pixel;
    assign snap = (acc_q == A_ACCUM) && fall;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    // The remainder always stays below the divisor, so the difference fits CNT_W bits.
    function automatic logic [CNT_W+SUM_W-1:0] div_step(
        input logic [CNT_W-1:0] rem,
        input logic [SUM_W-1:0] quo,
        input logic [CNT_W-1:0] dvs
    );
        logic [CNT_W:0]   shifted;
        logic [CNT_W-1:0] diff;
        shifted = {rem, quo[SUM_W-1]};
        diff    = shifted[CNT_W-1:0] - dvs;
        if (shifted >= {1'b0, dvs}) begin
            return {diff, quo[SUM_W-2:0], 1'b1};
        end
        return {shifted[CNT_W-1:0], quo[SUM_W-2:0], 1'b0};
    endfunction

    // Next divider step for both axes, sharing the snapshotted count as divisor
    always_comb begin
        {rem_x_d, quo_x_d} = div_step(rem_x_q, quo_x_q, hold_cnt_q);
        {rem_y_d, quo_y_d} = div_step(rem_y_q, quo_y_q, hold_cnt_q);
    end

    // Frame-edge tracking and per-frame accumulation FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fv_q    <= 1'b0;
            acc_q   <= A_SYNC;
            min_x_q <= '1;
            max_x_q <= '0;
            min_y_q <= '1;
            max_y_q <= '0;
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            fv_q <= frame_valid;
            case (acc_q)
                // A frame already running at reset release is skipped entirely
                A_SYNC: if (!frame_valid) acc_q <= A_WAIT;
                A_WAIT: begin
                    if (rise) begin
                        acc_q <= A_ACCUM;
                        if (hit) begin
                            min_x_q <= x;
                            max_x_q <= x;
                            min_y_q <= y;
                            max_y_q <= y;
                            cnt_q   <= CNT_W'(1);
                            sum_x_q <= SUM_W'(x);
                            sum_y_q <= SUM_W'(y);
                        end else begin
                            min_x_q <= '1;
                            max_x_q <= '0;
                            min_y_q <= '1;
                            max_y_q <= '0;
                            cnt_q   <= '0;
                            sum_x_q <= '0;
                            sum_y_q <= '0;
                        end
                    end
                end
                A_ACCUM: begin
                    if (fall) begin
                        acc_q <= A_WAIT;
                    end else if (hit) begin
                        if (x < min_x_q) min_x_q <= x;
                        if (x > max_x_q) max_x_q <= x;
                        if (y < min_y_q) min_y_q <= y;
                        if (y > max_y_q) max_y_q <= y;
                        if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                        sum_x_q <= sum_x_q + SUM_W'(x);
                        sum_y_q <= sum_y_q + SUM_W'(y);
                    end
                end
                default: acc_q <= A_SYNC;
            endcase
        end
    end

    // Snapshot, centroid division and result publication FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q          <= D_IDLE;
            hold_cnt_q     <= '0;
            hold_x_min_q   <= '0;
            hold_x_max_q   <= '0;
            hold_y_min_q   <= '0;
            hold_y_max_q   <= '0;
            quo_x_q        <= '0;
            quo_y_q        <= '0;
            rem_x_q        <= '0;
            rem_y_q        <= '0;
            step_q         <= '0;
            bbox_x_min_q   <= '0;
            bbox_x_max_q   <= '0;
            bbox_y_min_q   <= '0;
            bbox_y_max_q   <= '0;
            centroid_x_q   <= '0;
            centroid_y_q   <= '0;
            pixel_count_q  <= '0;
            object_found_q <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            // A frame ending while the previous one is still in flight is dropped
            if (snap && div_q != D_IDLE) overrun_q <= 1'b1;
            case (div_q)
                D_IDLE: begin
                    if (snap) begin
                        hold_cnt_q   <= cnt_q;
                        hold_x_min_q <= min_x_q;
                        hold_x_max_q <= max_x_q;
                        hold_y_min_q <= min_y_q;
                        hold_y_max_q <= max_y_q;
                        quo_x_q      <= sum_x_q;
                        quo_y_q      <= sum_y_q;
                        rem_x_q      <= '0;
                        rem_y_q      <= '0;
                        step_q       <= '0;
                        if (cnt_q >= MIN_CNT) begin
                            div_q  <= D_DIV;
                            busy_q <= 1'b1;
                        end else begin
                            div_q <= D_SHORT;
                        end
                    end
                end
                D_DIV: begin
                    if (step_q != LAST_STEP) begin
                        step_q  <= step_q + 1'b1;
                        quo_x_q <= quo_x_d;
                        quo_y_q <= quo_y_d;
                        rem_x_q <= rem_x_d;
                        rem_y_q <= rem_y_d;
                    end else begin
                        bbox_x_min_q   <= hold_x_min_q;
                        bbox_x_max_q   <= hold_x_max_q;
                        bbox_y_min_q   <= hold_y_min_q;
                        bbox_y_max_q   <= hold_y_max_q;
                        centroid_x_q   <= quo_x_q[X_W-1:0];
                        centroid_y_q   <= quo_y_q[Y_W-1:0];
                        pixel_count_q  <= hold_cnt_q;
                        object_found_q <= 1'b1;
                        result_valid_q <= 1'b1;
                        busy_q         <= 1'b0;
                        div_q          <= D_IDLE;
                    end
                end
                D_SHORT: begin
                    bbox_x_min_q   <= '0;
                    bbox_x_max_q   <= '0;
                    bbox_y_min_q   <= '0;
                    bbox_y_max_q   <= '0;
                    centroid_x_q   <= '0;
                    centroid_y_q   <= '0;
                    pixel_count_q  <= hold_cnt_q;
                    object_found_q <= 1'b0;
                    result_valid_q <= 1'b1;
                    div_q          <= D_IDLE;
                end
                default: div_q <= D_IDLE;
            endcase
        end
    end

    assign bbox_x_min   = bbox_x_min_q;
    assign bbox_x_max   = bbox_x_max_q;
    assign bbox_y_min   = bbox_y_min_q;
    assign bbox_y_max   = bbox_y_max_q;
    assign centroid_x   = centroid_x_q;
    assign centroid_y   = centroid_y_q;
    assign pixel_count  = pixel_count_q;
    assign object_found = object_found_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule
